// File: rtl/rom_fetch_ctrl.sv
`timescale 1ns/1ps
// rom_fetch_ctrl: front-end for a 1-cycle-latency ROM wrapper.
// After reset it sweeps the whole ROM once and builds an additive checksum.
// It then serves host reads. Grants are credit-limited so that every
// outstanding ROM read has a slot in the response FIFO, which lets the host
// stall responses without any ROM data being lost.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   host_req_i/addr_i  host read request and word address
//   host_gnt_o         request accepted this cycle (combinational)
//   host_rvalid_o      response FIFO not empty
//   host_rdata_o       response FIFO head
//   host_rready_i      host takes the head word
//   rom_req_o/addr_o   ROM read strobe and word address
//   rom_rvalid_i/rdata ROM response, one cycle after rom_req_o
//   check_done_o       sweep finished (sticky until reset)
//   check_sum_o        running / final sweep checksum
module rom_fetch_ctrl #(
   parameter int unsigned Width    = 32,
   parameter int unsigned Depth    = 2048,
   parameter int unsigned RspDepth = 2,
   localparam int unsigned Aw      = $clog2(Depth)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             host_req_i,
   input  logic [Aw-1:0]    host_addr_i,
   output logic             host_gnt_o,
   output logic             host_rvalid_o,
   output logic [Width-1:0] host_rdata_o,
   input  logic             host_rready_i,
   output logic             rom_req_o,
   output logic [Aw-1:0]    rom_addr_o,
   input  logic             rom_rvalid_i,
   input  logic [Width-1:0] rom_rdata_i,
   output logic             check_done_o,
   output logic [Width-1:0] check_sum_o
);

   localparam int unsigned PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
   // Wide enough for fifo count plus the in-flight read.
   localparam int unsigned CntW = $clog2(RspDepth + 2);

   typedef enum logic [1:0] {
      CHECK = 2'd0,
      DRAIN = 2'd1,
      SERVE = 2'd2
   } state_e;

   state_e           state_q;
   logic [Aw-1:0]    sweep_addr_q;
   logic             sweep_req_q;
   logic             inflight_q;
   logic [Width-1:0] sum_q;
   logic             done_q;

   logic [Width-1:0] mem_q [RspDepth];
   logic [PtrW-1:0]  wr_ptr_q;
   logic [PtrW-1:0]  rd_ptr_q;
   logic [CntW-1:0]  count_q;

   logic             serve;
   logic             rsp_ok;
   logic             push;
   logic             pop;
   logic             gnt_c;
   logic [CntW-1:0]  credit_used;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(RspDepth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   // A response only counts if a read is actually outstanding.
   assign serve  = (state_q == SERVE);
   assign rsp_ok = rom_rvalid_i & inflight_q;
   assign push   = serve & rsp_ok;
   assign pop    = host_rvalid_o & host_rready_i;

   // Grant only if the FIFO can absorb every read that will land in it.
   assign credit_used = count_q + CntW'(inflight_q) - CntW'(pop);
   assign gnt_c       = serve & host_req_i & (credit_used < CntW'(RspDepth));

   assign host_gnt_o    = gnt_c;
   assign host_rvalid_o = (count_q != '0);
   assign host_rdata_o  = mem_q[rd_ptr_q];
   assign rom_req_o     = serve ? gnt_c : sweep_req_q;
   assign rom_addr_o    = serve ? host_addr_i : sweep_addr_q;
   assign check_done_o  = done_q;
   assign check_sum_o   = sum_q;

   // Sweep/serve sequencer, checksum and in-flight tracking.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= CHECK;
         sweep_addr_q <= '0;
         sweep_req_q  <= 1'b0;
         inflight_q   <= 1'b0;
         sum_q        <= '0;
         done_q       <= 1'b0;
      end else begin
         inflight_q <= rom_req_o;
         if (!serve && rsp_ok) begin
            sum_q <= sum_q + rom_rdata_i;
         end
         unique case (state_q)
            CHECK: begin
               // First cycle out of reset only arms the strobe at address 0.
               if (!sweep_req_q) begin
                  sweep_req_q <= 1'b1;
               end else if (sweep_addr_q == Aw'(Depth - 1)) begin
                  sweep_req_q <= 1'b0;
                  state_q     <= DRAIN;
               end else begin
                  sweep_addr_q <= sweep_addr_q + Aw'(1);
               end
            end
            DRAIN: begin
               if (rsp_ok) begin
                  done_q  <= 1'b1;
                  state_q <= SERVE;
               end
            end
            SERVE: begin
               state_q <= SERVE;
            end
            default: begin
               state_q <= CHECK;
            end
         endcase
      end
   end

   // Response FIFO; circular buffer with an occupancy counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(RspDepth); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= rom_rdata_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         count_q <= count_q + CntW'(push) - CntW'(pop);
      end
   end

   a_rvalid_has_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
      rom_rvalid_i |-> inflight_q);

   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      push |-> (count_q != CntW'(RspDepth)));

   a_no_x_ctrl: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !$isunknown(host_req_i) && !$isunknown(rom_rvalid_i));

endmodule
